// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if
//   Byte-serial RAM port between the memory controller (master) and the
//   RAM/IO responder (slave). One access per cycle while rdy_in is high.
//   Signals:
//     rdy_in         master->slave  high = perform this cycle's access
//     mem_wr         master->slave  1 = write, 0 = read
//     mem_a          master->slave  byte address
//     mem_din        master->slave  write byte
//     mem_dout       slave->master  read byte, valid the cycle after the address
//     io_buffer_full slave->master  TX FIFO near-full back-pressure
interface ram_io_responder_if;
  logic        rdy_in;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;

  modport master (
    output rdy_in, mem_wr, mem_a, mem_din,
    input  mem_dout, io_buffer_full
  );

  modport slave (
    input  rdy_in, mem_wr, mem_a, mem_din,
    output mem_dout, io_buffer_full
  );
endinterface

// File: rtl/ram_io_responder.sv
// ram_io_responder
//   Responder end of the byte-serial RAM port. Addresses below IO_BASE hit an
//   on-chip byte RAM; IO_BASE is the TX-FIFO push / RX-byte pop register and
//   IO_BASE+4 is the status / simulation-halt register.
//   Ports:
//     clk_in, rst_in   clock, synchronous active-high reset
//     bus              controller port (slave modport)
//     tx_valid/tx_data TX FIFO head, tx_ready accepts it
//     rx_valid/rx_data incoming byte, rx_pop pulses when it is consumed
//     sim_halt         sticky, set by a write to IO_BASE+4
//     tx_overflow      sticky, set when a push finds the FIFO full
module ram_io_responder #(
  parameter int          ADDR_WIDTH  = 17,
  parameter logic [31:0] IO_BASE     = 32'h30000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FULL_MARGIN = 2,
  parameter string       INIT_FILE   = "test.data"
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ram_io_responder_if.slave  bus,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_pop,
  output logic               sim_halt,
  output logic               tx_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(FIFO_DEPTH - FULL_MARGIN);

  // Which register drives mem_dout: the RAM read latch or the IO read latch.
  typedef enum logic {SRC_IO, SRC_RAM} src_e;

  logic [7:0] ram_mem  [2**ADDR_WIDTH];
  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [7:0] ram_rdata_q;

  src_e             src_q, src_d;
  logic [7:0]       io_dout_q, io_dout_d;
  logic             rx_pop_q, rx_pop_d;
  logic             sim_halt_q, sim_halt_d;
  logic             tx_overflow_q, tx_overflow_d;
  logic             full_q, full_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                  is_io, is_data_reg, is_stat_reg;
  logic                  ram_we, ram_re, fifo_we, tx_pop;
  logic [ADDR_WIDTH-1:0] ram_addr;

  assign is_io       = bus.mem_a >= IO_BASE;
  assign is_data_reg = bus.mem_a == IO_BASE;
  assign is_stat_reg = bus.mem_a == IO_BASE + 32'd4;
  assign ram_addr    = bus.mem_a[ADDR_WIDTH-1:0];
  assign tx_valid    = count_q != '0;
  assign tx_pop      = tx_valid && tx_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    src_d         = src_q;
    io_dout_d     = io_dout_q;
    rx_pop_d      = 1'b0;
    sim_halt_d    = sim_halt_q;
    tx_overflow_d = tx_overflow_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    fifo_we       = 1'b0;

    // Reset wins over a concurrent access so nothing lands mid-reset.
    if (bus.rdy_in && !rst_in) begin
      if (!is_io) begin
        if (bus.mem_wr) begin
          ram_we = 1'b1;
        end else begin
          ram_re = 1'b1;
          src_d  = SRC_RAM;
        end
      end else if (bus.mem_wr) begin
        if (is_data_reg) begin
          // A simultaneous pop frees a slot, so a full FIFO still accepts.
          if (count_q != CNT_FULL || tx_pop) fifo_we = 1'b1;
          else                               tx_overflow_d = 1'b1;
        end
        if (is_stat_reg) sim_halt_d = 1'b1;
      end else begin
        src_d = SRC_IO;
        if (is_data_reg) begin
          io_dout_d = rx_valid ? rx_data : 8'h00;
          rx_pop_d  = rx_valid;
        end else if (is_stat_reg) begin
          io_dout_d = {6'b0, full_q, rx_valid};
        end else begin
          io_dout_d = 8'h00;
        end
      end
    end

    wr_ptr_d = fifo_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = tx_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(fifo_we) - CNT_W'(tx_pop);
    // Registered from next-state count: the controller sees it one cycle
    // late, which FULL_MARGIN covers together with one in-flight write.
    full_d   = count_d >= CNT_HIGH;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q         <= SRC_IO;
      io_dout_q     <= 8'h00;
      rx_pop_q      <= 1'b0;
      sim_halt_q    <= 1'b0;
      tx_overflow_q <= 1'b0;
      full_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      src_q         <= src_d;
      io_dout_q     <= io_dout_d;
      rx_pop_q      <= rx_pop_d;
      sim_halt_q    <= sim_halt_d;
      tx_overflow_q <= tx_overflow_d;
      full_q        <= full_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: storage arrays and the RAM read latch are deliberately not reset,
  // which keeps them mappable onto block RAM; reset zeroes mem_dout through
  // src_q/io_dout_q instead.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram_mem[ram_addr]   <= bus.mem_din;
    if (ram_re)  ram_rdata_q         <= ram_mem[ram_addr];
    if (fifo_we) fifo_mem[wr_ptr_q]  <= bus.mem_din;
  end

  assign bus.mem_dout       = (src_q == SRC_RAM) ? ram_rdata_q : io_dout_q;
  assign bus.io_buffer_full = full_q;
  assign tx_data            = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  assign rx_pop             = rx_pop_q;
  assign sim_halt           = sim_halt_q;
  assign tx_overflow        = tx_overflow_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
//   Directed self-checking bench for ram_io_responder (default parameters).
//   Inputs change 1 ns after the rising edge; outputs are compared there too.
module tb_ram_io_responder;
  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tx_valid, tx_ready, rx_valid, rx_pop, sim_halt, tx_overflow;
  logic [7:0] tx_data, rx_data;

  int vectors     = 0;
  int miscompares = 0;

  ram_io_responder_if bus ();

  ram_io_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bus.slave),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_pop      (rx_pop),
    .sim_halt    (sim_halt),
    .tx_overflow (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.rdy_in  = 1'b1;
    bus.mem_wr  = wr;
    bus.mem_a   = a;
    bus.mem_din = d;
    step();
  endtask

  task automatic pause(input int n);
    bus.rdy_in = 1'b0;
    bus.mem_wr = 1'b0;
    bus.mem_a  = 32'h0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    vectors++;
    if ({bus.mem_dout, bus.io_buffer_full, tx_valid, tx_data, rx_pop, sim_halt, tx_overflow}
        !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%h full=%b txv=%b txd=%h pop=%b halt=%b ovf=%b, want all 0",
               bus.mem_dout, bus.io_buffer_full, tx_valid, tx_data, rx_pop, sim_halt, tx_overflow);
    end
  endtask

  task automatic test_ram_rw();
    access(1'b1, 32'h10, 8'hA5);
    access(1'b0, 32'h10, 8'h00);
    vectors++;
    if (bus.mem_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL ram_rw: mem_dout=%h want a5", bus.mem_dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) access(1'b1, 32'h100 + 32'(i), pat[i]);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 32'h100 + 32'(i), 8'h00);
      vectors++;
      if (bus.mem_dout !== pat[i]) begin
        miscompares++;
        $display("FAIL b2b_read[%0d]: mem_dout=%h want %h", i, bus.mem_dout, pat[i]);
      end
    end
    // Paused cycles must hold the last read byte even with a new address.
    bus.rdy_in = 1'b0;
    bus.mem_a  = 32'h10;
    step();
    step();
    vectors++;
    if (bus.mem_dout !== 8'h44) begin
      miscompares++;
      $display("FAIL pause_hold: mem_dout=%h want 44", bus.mem_dout);
    end
  endtask

  task automatic test_tx_fifo();
    logic [7:0] drain [8];
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      access(1'b1, 32'h30000, 8'(i));
      if (i == 5 || i == 6) begin
        vectors++;
        if (bus.io_buffer_full !== (i == 6)) begin
          miscompares++;
          $display("FAIL full_after_%0d: io_buffer_full=%b want %b", i, bus.io_buffer_full, i == 6);
        end
      end
    end
    vectors++;
    if ({tx_valid, tx_data, tx_overflow} !== {1'b1, 8'h01, 1'b0}) begin
      miscompares++;
      $display("FAIL fill8: txv=%b txd=%h ovf=%b want 1 01 0", tx_valid, tx_data, tx_overflow);
    end
    // Push and pop together at count 8: no drop, head advances in order.
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (tx_data !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL pushpop_head[%0d]: tx_data=%h want %h", i, tx_data, 8'(i + 1));
      end
      access(1'b1, 32'h30000, 8'hA0 + 8'(i));
    end
    vectors++;
    if ({bus.io_buffer_full, tx_overflow} !== 2'b10) begin
      miscompares++;
      $display("FAIL pushpop_flags: full=%b ovf=%b want 1 0", bus.io_buffer_full, tx_overflow);
    end
    // Push into a full FIFO with no pop: dropped, sticky overflow.
    tx_ready = 1'b0;
    access(1'b1, 32'h30000, 8'hFF);
    vectors++;
    if (tx_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: tx_overflow=%b want 1", tx_overflow);
    end
    // Drain with the bus paused; the dropped FF must not appear.
    drain[0] = 8'h05; drain[1] = 8'h06; drain[2] = 8'h07; drain[3] = 8'h08;
    drain[4] = 8'hA0; drain[5] = 8'hA1; drain[6] = 8'hA2; drain[7] = 8'hA3;
    tx_ready   = 1'b1;
    bus.rdy_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({tx_valid, tx_data} !== {1'b1, drain[i]}) begin
        miscompares++;
        $display("FAIL drain[%0d]: txv=%b txd=%h want 1 %h", i, tx_valid, tx_data, drain[i]);
      end
      step();
    end
    vectors++;
    if ({tx_valid, tx_data, bus.io_buffer_full} !== 10'h0) begin
      miscompares++;
      $display("FAIL drained: txv=%b txd=%h full=%b want 0 00 0", tx_valid, tx_data, bus.io_buffer_full);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_io();
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    access(1'b0, 32'h30000, 8'h00);
    vectors++;
    if ({bus.mem_dout, rx_pop} !== {8'h41, 1'b1}) begin
      miscompares++;
      $display("FAIL rx_read: dout=%h pop=%b want 41 1", bus.mem_dout, rx_pop);
    end
    pause(1);
    vectors++;
    if (rx_pop !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_pop_pulse: rx_pop=%b want 0", rx_pop);
    end
    access(1'b0, 32'h30004, 8'h00);
    vectors++;
    if ({bus.mem_dout, rx_pop} !== {8'h01, 1'b0}) begin
      miscompares++;
      $display("FAIL status_read: dout=%h pop=%b want 01 0", bus.mem_dout, rx_pop);
    end
    access(1'b0, 32'h30008, 8'h00);
    vectors++;
    if (bus.mem_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL other_io: dout=%h want 00", bus.mem_dout);
    end
    rx_valid = 1'b0;
    access(1'b0, 32'h100, 8'h00);
    access(1'b0, 32'h30000, 8'h00);
    vectors++;
    if ({bus.mem_dout, rx_pop} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL rx_empty: dout=%h pop=%b want 00 0", bus.mem_dout, rx_pop);
    end
  endtask

  task automatic test_halt_reset();
    access(1'b1, 32'h30004, 8'h00);
    pause(2);
    vectors++;
    if (sim_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_halt: sim_halt=%b want 1", sim_halt);
    end
    access(1'b1, 32'h30000, 8'h5A);
    access(1'b1, 32'h30000, 8'h5B);
    vectors++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL prereset_fifo: txv=%b txd=%h want 1 5a", tx_valid, tx_data);
    end
    // One reset cycle with a RAM read in flight: result discarded.
    rst_in = 1'b1;
    access(1'b0, 32'h10, 8'h00);
    rst_in = 1'b0;
    vectors++;
    if ({tx_valid, sim_halt, bus.mem_dout} !== 10'h0) begin
      miscompares++;
      $display("FAIL midreset: txv=%b halt=%b dout=%h want 0 0 00", tx_valid, sim_halt, bus.mem_dout);
    end
    access(1'b0, 32'h10, 8'h00);
    vectors++;
    if (bus.mem_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL ram_survives_reset: dout=%h want a5", bus.mem_dout);
    end
  endtask

  initial begin
    rst_in      = 1'b1;
    bus.rdy_in  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.mem_a   = 32'h0;
    bus.mem_din = 8'h00;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    test_reset();
    test_ram_rw();
    test_back_to_back();
    test_tx_fifo();
    test_rx_io();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
